// File: rtl/stack_alu_unit_pkg.sv
// Shared encodings for the operand-stack ALU front end: command codes, ALU opcodes,
// FSM state type and opcode classification helpers.
package stack_alu_unit_pkg;

    localparam logic [1:0] CMD_PUSH = 2'd0;
    localparam logic [1:0] CMD_POP  = 2'd1;
    localparam logic [1:0] CMD_OP   = 2'd2;
    localparam logic [1:0] CMD_RSVD = 2'd3;

    localparam logic [3:0] ALUOP_ADD = 4'd0;
    localparam logic [3:0] ALUOP_SUB = 4'd1;
    localparam logic [3:0] ALUOP_SLL = 4'd2;
    localparam logic [3:0] ALUOP_SRL = 4'd3;
    localparam logic [3:0] ALUOP_AND = 4'd4;
    localparam logic [3:0] ALUOP_OR  = 4'd5;
    localparam logic [3:0] ALUOP_XOR = 4'd6;
    localparam logic [3:0] ALUOP_NOT = 4'd7;
    localparam logic [3:0] ALUOP_NEG = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    function automatic logic is_unary(input logic [3:0] op);
        return (op == ALUOP_NOT) || (op == ALUOP_NEG);
    endfunction

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= ALUOP_NOT) || (op == ALUOP_NEG);
    endfunction

endpackage

// File: rtl/stack_alu_unit_alu16b.sv
// Combinational 16-bit ALU: arithmetic with signed overflow, shifts, logic ops,
// bitwise NOT and two's-complement negate.
module alu16b
    import stack_alu_unit_pkg::*;
(
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [3:0]  ALUop,
    output logic [15:0] S,
    output logic        IsZero,
    output logic        OFL
);

    always_comb begin
        S   = 16'h0000;
        OFL = 1'b0;
        case (ALUop)
            ALUOP_ADD: begin
                S   = A + B;
                OFL = (A[15] == B[15]) && (S[15] != A[15]);
            end
            ALUOP_SUB: begin
                S   = A - B;
                OFL = (A[15] != B[15]) && (S[15] != A[15]);
            end
            ALUOP_SLL: S = A << B;
            ALUOP_SRL: S = A >> B;
            ALUOP_AND: S = A & B;
            ALUOP_OR:  S = A | B;
            ALUOP_XOR: S = A ^ B;
            ALUOP_NOT: S = ~A;
            ALUOP_NEG: begin
                S   = 16'h0000 - A;
                OFL = (A == 16'h8000);
            end
            default: S = 16'h0000;
        endcase
    end

    assign IsZero = (S == 16'h0000);

endmodule

// File: rtl/stack_alu_unit.sv
// Operand stack in front of alu16b: accepts PUSH/POP/OP commands, pops operands,
// runs the ALU over EXEC/WB and pushes the result back.
module stack_alu_unit
    import stack_alu_unit_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PW    = 3
) (
    input  logic          CLK,
    input  logic          Reset_n,
    input  logic          CmdValid,
    output logic          CmdReady,
    input  logic [1:0]    Cmd,
    input  logic [3:0]    CmdOp,
    input  logic [15:0]   CmdData,
    output logic [15:0]   Tos,
    output logic [PW:0]   Depth,
    output logic          Done,
    output logic          Err,
    output logic          ZeroFlag,
    output logic          OflFlag,
    output state_t        fsm_state
);

    state_t state, next_state;

    logic [15:0] stack [DEPTH];
    logic [15:0] a_q, b_q, s_q;
    logic [3:0]  op_q;
    logic        z_q, o_q, unary_q;
    logic [15:0] alu_s;
    logic        alu_z, alu_o;

    logic          accept, do_push, do_pop, do_op, cmd_err, wb, op_unary;
    logic [PW-1:0] top_idx, nos_idx, push_idx;

    assign top_idx   = Depth[PW-1:0] - PW'(1);
    assign nos_idx   = Depth[PW-1:0] - PW'(2);
    assign push_idx  = Depth[PW-1:0];
    assign fsm_state = state;

    // A command transfers on the rising edge where CmdValid && CmdReady; CmdReady is high
    // exactly in IDLE, and a CmdValid seen while CmdReady is low is simply not taken.
    always_comb begin
        CmdReady   = (state == ST_IDLE);
        accept     = CmdValid && CmdReady;
        op_unary   = is_unary(CmdOp);
        do_push    = 1'b0;
        do_pop     = 1'b0;
        do_op      = 1'b0;
        wb         = (state == ST_WB);
        next_state = state;
        if (accept) begin
            case (Cmd)
                CMD_PUSH: do_push = (Depth != (PW+1)'(DEPTH));
                CMD_POP:  do_pop  = (Depth != '0);
                CMD_OP:   do_op   = is_legal_op(CmdOp) &&
                                    (op_unary ? (Depth != '0) : (Depth >= (PW+1)'(2)));
                default:  ;
            endcase
        end
        cmd_err = accept && !(do_push || do_pop || do_op);
        case (state)
            ST_IDLE: if (do_op) next_state = ST_EXEC;
            ST_EXEC: next_state = ST_WB;
            ST_WB:   next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    alu16b u_alu (
        .A      (a_q),
        .B      (b_q),
        .ALUop  (op_q),
        .S      (alu_s),
        .IsZero (alu_z),
        .OFL    (alu_o)
    );

    // Array contents are meaningless while Depth says so, hence no reset here.
    always_ff @(posedge CLK) begin
        if (do_push)
            stack[push_idx] <= CmdData;
        else if (wb && Reset_n)
            stack[unary_q ? top_idx : nos_idx] <= s_q;
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            Depth    <= '0;
            Tos      <= 16'h0000;
            Done     <= 1'b0;
            Err      <= 1'b0;
            ZeroFlag <= 1'b0;
            OflFlag  <= 1'b0;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            op_q     <= 4'h0;
            s_q      <= 16'h0000;
            z_q      <= 1'b0;
            o_q      <= 1'b0;
            unary_q  <= 1'b0;
        end else begin
            Done <= do_push || do_pop || cmd_err || wb;
            Err  <= cmd_err;
            if (do_push) begin
                Depth <= Depth + 1'b1;
                Tos   <= CmdData;
            end
            if (do_pop) begin
                Depth <= Depth - 1'b1;
                Tos   <= (Depth >= (PW+1)'(2)) ? stack[nos_idx] : 16'h0000;
            end
            if (do_op) begin
                a_q     <= op_unary ? Tos : stack[nos_idx];
                b_q     <= op_unary ? 16'h0000 : Tos;
                op_q    <= CmdOp;
                unary_q <= op_unary;
            end
            if (state == ST_EXEC) begin
                s_q <= alu_s;
                z_q <= alu_z;
                o_q <= alu_o;
            end
            if (wb) begin
                Tos      <= s_q;
                ZeroFlag <= z_q;
                OflFlag  <= o_q;
                if (!unary_q) Depth <= Depth - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stack_alu_unit.sv
// Directed bench for stack_alu_unit: hand-computed expectations for stack, ALU and
// error behaviour, including a reset that lands in the middle of an OP.
module tb_stack_alu_unit;
    import stack_alu_unit_pkg::*;

    localparam int DEPTH = 8;
    localparam int PW    = 3;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd;
    logic [3:0]    cmd_op;
    logic [15:0]   cmd_data;
    logic [15:0]   tos;
    logic [PW:0]   depth;
    logic          done;
    logic          err;
    logic          zero_flag;
    logic          ofl_flag;
    state_t        fsm_state;

    int n_checks = 0;
    int n_fails  = 0;
    logic last_err;

    stack_alu_unit #(.DEPTH(DEPTH), .PW(PW)) dut (
        .CLK       (clk),
        .Reset_n   (rst_n),
        .CmdValid  (cmd_valid),
        .CmdReady  (cmd_ready),
        .Cmd       (cmd),
        .CmdOp     (cmd_op),
        .CmdData   (cmd_data),
        .Tos       (tos),
        .Depth     (depth),
        .Done      (done),
        .Err       (err),
        .ZeroFlag  (zero_flag),
        .OflFlag   (ofl_flag),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drive one command and wait (bounded) for its Done pulse; Err is latched into last_err.
    task automatic issue(input logic [1:0] c, input logic [3:0] op, input logic [15:0] data);
        int n;
        cmd       = c;
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (!done && n < 8) begin
            @(posedge clk);
            #1 n++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
        last_err = err;
    endtask

    task automatic push(input logic [15:0] v);
        issue(CMD_PUSH, 4'h0, v);
    endtask

    task automatic pop();
        issue(CMD_POP, 4'h0, 16'h0);
    endtask

    task automatic alu_op(input logic [3:0] op);
        issue(CMD_OP, op, 16'h0);
    endtask

    initial begin
        cmd = 2'd0; cmd_op = 4'd0; cmd_data = 16'd0;
        last_err = 1'b0;

        // 1: reset state, then 500 - 600
        do_reset();
        check("rst_depth", 32'(depth), 32'd0);
        check("rst_tos", 32'(tos), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_flags", {30'd0, zero_flag, ofl_flag}, 32'd0);
        check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        push(16'd500);
        check("push_err", 32'(last_err), 32'd0);
        @(posedge clk); #1;
        check("done_pulse_width", 32'(done), 32'd0);
        push(16'd600);
        check("push_tos", 32'(tos), 32'd600);
        alu_op(ALUOP_SUB);
        check("sub_tos", 32'(tos), 32'hFF9C);
        check("sub_depth", 32'(depth), 32'd1);
        check("sub_zero", 32'(zero_flag), 32'd0);
        check("sub_ofl", 32'(ofl_flag), 32'd0);
        check("sub_err", 32'(last_err), 32'd0);

        // 2: signed overflow on add, then wrap to zero
        do_reset();
        push(16'd32767);
        push(16'd1);
        alu_op(ALUOP_ADD);
        check("add_ofl_tos", 32'(tos), 32'h8000);
        check("add_ofl_flag", 32'(ofl_flag), 32'd1);
        push(16'h8000);
        check("push_keeps_ofl", 32'(ofl_flag), 32'd1);
        alu_op(ALUOP_ADD);
        check("add_zero_tos", 32'(tos), 32'd0);
        check("add_zero_flag", 32'(zero_flag), 32'd1);
        check("add_zero_ofl", 32'(ofl_flag), 32'd1);
        check("add_zero_depth", 32'(depth), 32'd1);

        // 3: unary ops and an illegal opcode
        do_reset();
        push(16'd0);
        alu_op(ALUOP_NOT);
        check("not_tos", 32'(tos), 32'hFFFF);
        check("not_depth", 32'(depth), 32'd1);
        alu_op(ALUOP_NEG);
        check("neg_tos", 32'(tos), 32'h0001);
        alu_op(4'd8);
        check("illegal_err", 32'(last_err), 32'd1);
        check("illegal_tos", 32'(tos), 32'h0001);

        // 4: underflow errors
        do_reset();
        push(16'h1234);
        alu_op(ALUOP_ADD);
        check("bin_short_err", 32'(last_err), 32'd1);
        check("bin_short_depth", 32'(depth), 32'd1);
        pop();
        check("pop1_err", 32'(last_err), 32'd0);
        pop();
        check("pop2_err", 32'(last_err), 32'd1);
        check("pop2_depth", 32'(depth), 32'd0);
        check("pop2_tos", 32'(tos), 32'd0);
        issue(CMD_RSVD, 4'h0, 16'h0);
        check("rsvd_err", 32'(last_err), 32'd1);

        // 5: fill, overflow, then a shift
        do_reset();
        for (int i = 1; i <= DEPTH; i++) push(16'(i));
        check("full_depth", 32'(depth), 32'(DEPTH));
        push(16'hAAAA);
        check("full_err", 32'(last_err), 32'd1);
        check("full_tos", 32'(tos), 32'(DEPTH));
        pop();
        pop();
        check("pop_tos", 32'(tos), 32'(DEPTH - 2));
        push(16'h00F0);
        push(16'd4);
        alu_op(ALUOP_SRL);
        check("srl_tos", 32'(tos), 32'h000F);
        check("srl_depth", 32'(depth), 32'(DEPTH - 1));

        // 6: reset while the op is in EXEC
        do_reset();
        push(16'd7);
        push(16'd7);
        cmd = CMD_OP; cmd_op = ALUOP_XOR; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check("exec_state", 32'(fsm_state), 32'(ST_EXEC));
        check("exec_ready", 32'(cmd_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_depth", 32'(depth), 32'd0);
        check("abort_tos", 32'(tos), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_ready", 32'(cmd_ready), 32'd1);
        check("abort_depth2", 32'(depth), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
